// File: rtl/seg7_monitor_if.sv
// Segment-bus monitor interface: the bench/driver side owns hex_in,
// and the monitor side returns the decoded digit, the error and step pulses, and the change counter.
interface seg7_monitor_if;
  logic [6:0] hex_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       seg_err;
  logic       step_valid;
  logic [2:0] step;
  logic [7:0] change_cnt;

  modport master (
    output hex_in,
    input  digit, digit_valid, seg_err, step_valid, step, change_cnt
  );

  modport slave (
    input  hex_in,
    output digit, digit_valid, seg_err, step_valid, step, change_cnt
  );
endinterface

// File: rtl/seg7_monitor.sv
// Seven-segment bus checker: filters the active-low bus for stability and decodes it to a hex digit.
// It also flags illegal glyphs and classifies the step between successive valid digits.
module seg7_monitor #(
   parameter int STABLE_CYCLES = 4
) (
   input logic         clk,
   input logic         resetn,
   seg7_monitor_if.slave bus
);

   typedef enum logic {EMPTY, LOCKED} state_t;
   typedef enum logic [2:0] {HOLD = 3'd0, INC1 = 3'd1, INC2 = 3'd2, DEC1 = 3'd3, JUMP = 3'd4} step_t;

   localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES - 1);

   state_t     state;
   logic [6:0] samp;
   logic [3:0] run;
   logic [6:0] ref_pat;
   logic [3:0] prev;
   logic       prev_ok;

   logic [3:0] digit_q;
   logic       digit_valid_q;
   logic       seg_err_q;
   logic       step_valid_q;
   step_t      step_q;
   logic [7:0] change_cnt_q;

   logic       legal;
   logic [3:0] val;
   logic [4:0] diff;
   step_t      step_nxt;
   logic       accept;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      legal = 1'b1;
      val   = 4'h0;
      unique case (samp)
         7'b1000000: val = 4'h0;
         7'b1111001: val = 4'h1;
         7'b0100100: val = 4'h2;
         7'b0110000: val = 4'h3;
         7'b0011001: val = 4'h4;
         7'b0010010: val = 4'h5;
         7'b0000010: val = 4'h6;
         7'b1111000: val = 4'h7;
         7'b0000000: val = 4'h8;
         7'b0010000: val = 4'h9;
         7'b0001000: val = 4'hA;
         7'b0000011: val = 4'hB;
         7'b1000110: val = 4'hC;
         7'b0100001: val = 4'hD;
         7'b0000110: val = 4'hE;
         7'b0001110: val = 4'hF;
         default:    legal = 1'b0;
      endcase
   end

   // Decimal distance modulo 10, so the 9->0 and 0->9 wraps read as single steps.
   always_comb begin
      diff = {1'b0, val} - {1'b0, prev};
      if (diff[4]) diff = diff + 5'd10;
      step_nxt = JUMP;
      if (prev <= 4'd9 && val <= 4'd9) begin
         case (diff)
            5'd0:    step_nxt = HOLD;
            5'd1:    step_nxt = INC1;
            5'd2:    step_nxt = INC2;
            5'd9:    step_nxt = DEC1;
            default: step_nxt = JUMP;
         endcase
      end
   end

   assign accept = (run == RUN_MAX) && (state == EMPTY || samp != ref_pat);

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= EMPTY;
         samp          <= 7'h7F;
         run           <= 4'd0;
         ref_pat       <= 7'd0;
         prev          <= 4'd0;
         prev_ok       <= 1'b0;
         digit_q       <= 4'd0;
         digit_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
         step_valid_q  <= 1'b0;
         step_q        <= HOLD;
         change_cnt_q  <= 8'd0;
      end else begin
         samp <= bus.hex_in;
         if (bus.hex_in != samp) run <= 4'd0;
         else if (run != RUN_MAX) run <= run + 4'd1;

         digit_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
         step_valid_q  <= 1'b0;

         if (accept) begin
            state   <= LOCKED;
            ref_pat <= samp;
            if (legal) begin
               digit_q       <= val;
               digit_valid_q <= 1'b1;
               if (change_cnt_q != 8'hFF) change_cnt_q <= change_cnt_q + 8'd1;
               if (prev_ok) begin
                  step_valid_q <= 1'b1;
                  step_q       <= step_nxt;
               end
               prev    <= val;
               prev_ok <= 1'b1;
            end else begin
               seg_err_q <= 1'b1;
               prev_ok   <= 1'b0;
            end
         end
      end
   end

   assign bus.digit       = digit_q;
   assign bus.digit_valid = digit_valid_q;
   assign bus.seg_err     = seg_err_q;
   assign bus.step_valid  = step_valid_q;
   assign bus.step        = step_q;
   assign bus.change_cnt  = change_cnt_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: a reference model queues each expected acceptance,
// and a negedge monitor pops and compares it when the DUT pulses.
module tb_seg7_monitor;
   localparam int S = 4;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   typedef struct {
      bit         is_err;
      logic [3:0] digit;
      bit         sv;
      logic [2:0] step;
      logic [7:0] cnt;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t q[$];

   bit         m_empty;
   logic [6:0] m_ref;
   logic [3:0] m_digit, m_prev;
   bit         m_prev_ok;
   int         m_cnt;

   seg7_monitor_if mif();

   seg7_monitor #(.STABLE_CYCLES(S)) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (mif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int tb_decode(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (p == GLYPH[i]) return i;
      return -1;
   endfunction

   function automatic logic [2:0] exp_step(input int p, input int v);
      int d;
      if (p > 9 || v > 9) return 3'd4;
      d = (v + 10 - p) % 10;
      case (d)
         0:       return 3'd0;
         1:       return 3'd1;
         2:       return 3'd2;
         9:       return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   task automatic model_reset();
      m_empty = 1; m_ref = 7'd0; m_digit = 4'd0; m_prev = 4'd0; m_prev_ok = 0; m_cnt = 0;
   endtask

   // Pattern p first sampled on edge k and held n edges.
   task automatic model_step(input logic [6:0] p, input int n, input int k);
      exp_t e;
      int   v;
      if (n >= S && (m_empty || p != m_ref)) begin
         m_empty = 0;
         m_ref   = p;
         v       = tb_decode(p);
         e.cyc   = k + S;
         if (v < 0) begin
            e.is_err = 1; e.digit = m_digit; e.sv = 0; e.step = 3'd0; e.cnt = 8'(m_cnt);
            m_prev_ok = 0;
         end else begin
            m_digit = 4'(v);
            if (m_cnt < 255) m_cnt++;
            e.is_err = 0; e.digit = 4'(v); e.sv = m_prev_ok;
            e.step = exp_step(int'(m_prev), v); e.cnt = 8'(m_cnt);
            m_prev = 4'(v); m_prev_ok = 1;
         end
         q.push_back(e);
      end
   endtask

   task automatic drive(input logic [6:0] p, input int n);
      @(negedge clk);
      mif.hex_in = p;
      model_step(p, n, cyc + 1);
      repeat (n) @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].cyc < cyc) begin
         check("missed_pulse", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (mif.digit_valid || mif.seg_err) begin
         check("single_pulse", mif.digit_valid & mif.seg_err, 0);
         if (q.size() == 0) begin
            check("unexpected_pulse", {mif.digit_valid, mif.seg_err}, 0);
         end else begin
            e = q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("seg_err", mif.seg_err, e.is_err);
            check("digit_valid", mif.digit_valid, !e.is_err);
            check("digit", mif.digit, e.digit);
            check("step_valid", mif.step_valid, e.sv);
            if (e.sv) check("step", mif.step, e.step);
            check("change_cnt", mif.change_cnt, e.cnt);
         end
      end else begin
         check("stray_step_valid", mif.step_valid, 0);
      end
   end

   initial begin
      int k;
      mif.hex_in = GLYPH[0];
      model_reset();
      do_reset();
      check("rst_digit", mif.digit, 0);
      check("rst_digit_valid", mif.digit_valid, 0);
      check("rst_seg_err", mif.seg_err, 0);
      check("rst_step_valid", mif.step_valid, 0);
      check("rst_step", mif.step, 0);
      check("rst_change_cnt", mif.change_cnt, 0);

      // First digit after reset: no step, count 1.
      drive(GLYPH[3], 6);
      @(negedge clk);
      check("first_cnt", mif.change_cnt, 1);
      check("first_digit", mif.digit, 3);

      // Increment chain including the decimal wraps.
      do_reset();
      drive(GLYPH[7], 6);
      drive(GLYPH[8], 6);
      drive(GLYPH[9], 6);
      drive(GLYPH[0], 6);
      drive(GLYPH[2], 6);
      @(negedge clk);
      check("chain_cnt", mif.change_cnt, 5);
      check("chain_last_step", mif.step, 2);
      drive(GLYPH[0], 6);
      drive(GLYPH[9], 6);
      @(negedge clk);
      check("dec1_step", mif.step, 3);
      drive(GLYPH[12], 6);
      @(negedge clk);
      check("jump_step", mif.step, 4);
      check("jump_digit", mif.digit, 12);

      // Short glitch is filtered; returning to the accepted glyph stays silent.
      do_reset();
      drive(GLYPH[5], 6);
      drive(GLYPH[8], 2);
      drive(GLYPH[5], 6);
      drive(GLYPH[8], S - 1);
      drive(GLYPH[5], 6);
      @(negedge clk);
      check("glitch_cnt", mif.change_cnt, 1);

      // Illegal glyph breaks the step chain.
      drive(GLYPH[4], 6);
      drive(7'h7F, 6);
      @(negedge clk);
      check("illegal_digit", mif.digit, 4);
      drive(GLYPH[5], 6);

      // Counter saturation, each glyph held exactly the minimum stable length.
      do_reset();
      for (int i = 0; i < 260; i++) drive(GLYPH[i % 2], S);
      repeat (2) @(negedge clk);
      check("sat_cnt", mif.change_cnt, 255);

      // Reset on the accepting edge wins; the glyph is re-accepted afterwards as the first digit.
      drive(GLYPH[2], 6);
      @(negedge clk);
      mif.hex_in = GLYPH[6];
      repeat (S) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check("mid_rst_digit", mif.digit, 0);
      check("mid_rst_digit_valid", mif.digit_valid, 0);
      check("mid_rst_seg_err", mif.seg_err, 0);
      check("mid_rst_step_valid", mif.step_valid, 0);
      check("mid_rst_change_cnt", mif.change_cnt, 0);
      resetn = 1'b1;
      model_reset();
      k = cyc + 1;
      model_step(GLYPH[6], 6, k);
      repeat (6) @(posedge clk);
      repeat (2) @(negedge clk);
      check("post_rst_digit", mif.digit, 6);
      check("post_rst_cnt", mif.change_cnt, 1);

      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
